piece_drop_controller: RTL and testbench

//  Sequences one falling piece at a time: pulses the shape generator's newShape, captures
//  the 4 spawn squares and shape colour, and drops the piece one cell every DROP_FRAMES frames.

---
 rtl/piece_drop_controller_if.sv | 30 +++
 rtl/piece_drop_controller.sv | 165 ++++++++++++++++
 tb/tb_piece_drop_controller.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/piece_drop_controller_if.sv
// rtl/piece_drop_controller_if.sv - probe/lock handshake between the piece controller and the board
interface piece_drop_controller_if;
    logic       probe_valid;
    logic [9:0] probe_x [4];
    logic [9:0] probe_y [4];
    logic       probe_ack;
    logic       probe_hit;
    logic       lock_valid;
    logic       lock_ack;

    modport master (
        output probe_valid,
        output probe_x,
        output probe_y,
        output lock_valid,
        input  probe_ack,
        input  probe_hit,
        input  lock_ack
    );

    modport slave (
        input  probe_valid,
        input  probe_x,
        input  probe_y,
        input  lock_valid,
        output probe_ack,
        output probe_hit,
        output lock_ack
    );
endinterface

// File: rtl/piece_drop_controller.sv
// rtl/piece_drop_controller.sv - spawns, drops and locks one falling piece at a time
module piece_drop_controller #(
    parameter int CELL        = 24,
    parameter int Y_MAX       = 456,
    parameter int DROP_FRAMES = 30,
    parameter int FAST_FRAMES = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       fast_drop,
    input  logic [9:0] gen_x [4],
    input  logic [9:0] gen_y [4],
    input  logic [6:0] gen_shape,
    output logic       newShape,
    output logic [9:0] sq_x [4],
    output logic [9:0] sq_y [4],
    output logic [6:0] shape,
    output logic       game_over,
    piece_drop_controller_if.master board
);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_SPAWN       = 3'd1;
    localparam logic [2:0] S_LOAD        = 3'd2;
    localparam logic [2:0] S_PROBE_SPAWN = 3'd3;
    localparam logic [2:0] S_FALL        = 3'd4;
    localparam logic [2:0] S_PROBE_DROP  = 3'd5;
    localparam logic [2:0] S_LOCK        = 3'd6;
    localparam logic [2:0] S_GAME_OVER   = 3'd7;

    localparam int MAX_FRAMES = (DROP_FRAMES > FAST_FRAMES) ? DROP_FRAMES : FAST_FRAMES;
    localparam int CW         = $clog2(MAX_FRAMES + 1);

    logic [2:0]    state;
    logic [CW-1:0] frame_cnt;
    logic [31:0]   cnt_next;
    logic [31:0]   threshold;
    logic          step_due;
    logic          at_bottom;
    logic [9:0]    drop_y [4];
    logic          probe_done;

    assign newShape         = (state == S_SPAWN);
    assign game_over        = (state == S_GAME_OVER);
    assign board.lock_valid = (state == S_LOCK);
    assign probe_done       = board.probe_valid && board.probe_ack;

    // Threshold is sampled per tick, so a mid-count speed change keeps the count.
    assign cnt_next  = 32'(frame_cnt) + 32'd1;
    assign threshold = fast_drop ? 32'(FAST_FRAMES) : 32'(DROP_FRAMES);
    assign step_due  = (cnt_next >= threshold);

    // Bottom check at 11 bits so a y near 1023 cannot wrap into a legal value.
    always_comb begin
        at_bottom = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drop_y[i] = sq_y[i] + 10'(CELL);
            if (({1'b0, sq_y[i]} + 11'(CELL)) > 11'(Y_MAX))
                at_bottom = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state             <= S_IDLE;
            frame_cnt         <= '0;
            shape             <= '0;
            board.probe_valid <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                sq_x[i]          <= '0;
                sq_y[i]          <= '0;
                board.probe_x[i] <= '0;
                board.probe_y[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start)
                        state <= S_SPAWN;
                end

                // The generator advances on this edge, so its current squares are taken now.
                S_SPAWN: begin
                    for (int i = 0; i < 4; i++) begin
                        sq_x[i] <= gen_x[i];
                        sq_y[i] <= gen_y[i];
                    end
                    state <= S_LOAD;
                end

                S_LOAD: begin
                    shape             <= gen_shape;
                    board.probe_valid <= 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        board.probe_x[i] <= sq_x[i];
                        board.probe_y[i] <= sq_y[i];
                    end
                    state <= S_PROBE_SPAWN;
                end

                S_PROBE_SPAWN: begin
                    if (probe_done) begin
                        board.probe_valid <= 1'b0;
                        frame_cnt         <= '0;
                        state             <= board.probe_hit ? S_GAME_OVER : S_FALL;
                    end
                end

                S_FALL: begin
                    if (frame_tick) begin
                        if (step_due) begin
                            frame_cnt <= '0;
                            if (at_bottom) begin
                                state <= S_LOCK;
                            end else begin
                                board.probe_valid <= 1'b1;
                                for (int i = 0; i < 4; i++) begin
                                    board.probe_x[i] <= sq_x[i];
                                    board.probe_y[i] <= drop_y[i];
                                end
                                state <= S_PROBE_DROP;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end

                S_PROBE_DROP: begin
                    if (probe_done) begin
                        board.probe_valid <= 1'b0;
                        if (board.probe_hit) begin
                            state <= S_LOCK;
                        end else begin
                            for (int i = 0; i < 4; i++)
                                sq_y[i] <= drop_y[i];
                            state <= S_FALL;
                        end
                    end
                end

                S_LOCK: begin
                    if (board.lock_ack)
                        state <= S_SPAWN;
                end

                S_GAME_OVER: begin
                    if (start) begin
                        shape <= '0;
                        for (int i = 0; i < 4; i++) begin
                            sq_x[i] <= '0;
                            sq_y[i] <= '0;
                        end
                        state <= S_SPAWN;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piece_drop_controller.sv
// tb/tb_piece_drop_controller.sv - directed self-checking bench for piece_drop_controller
module tb_piece_drop_controller;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       start = 1'b0;
    logic       frame_tick = 1'b0;
    logic       fast_drop = 1'b0;
    logic [9:0] gen_x [4];
    logic [9:0] gen_y [4];
    logic [6:0] gen_shape;
    logic       newShape;
    logic [9:0] sq_x [4];
    logic [9:0] sq_y [4];
    logic [6:0] shape;
    logic       game_over;

    int tests = 0;
    int fails = 0;

    logic [9:0] ax [4] = '{10'd120, 10'd120, 10'd120, 10'd144};
    logic [9:0] ay [4] = '{10'd24,  10'd48,  10'd72,  10'd72};
    logic [9:0] bx [4] = '{10'd96,  10'd120, 10'd144, 10'd120};
    logic [9:0] by [4] = '{10'd0,   10'd0,   10'd0,   10'd24};

    piece_drop_controller_if bif();

    piece_drop_controller dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .start      (start),
        .frame_tick (frame_tick),
        .fast_drop  (fast_drop),
        .gen_x      (gen_x),
        .gen_y      (gen_y),
        .gen_shape  (gen_shape),
        .newShape   (newShape),
        .sq_x       (sq_x),
        .sq_y       (sq_y),
        .shape      (shape),
        .game_over  (game_over),
        .board      (bif)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic ack_probe(input logic hit);
        bif.probe_ack = 1'b1;
        bif.probe_hit = hit;
        step();
        bif.probe_ack = 1'b0;
        bif.probe_hit = 1'b0;
    endtask

    task automatic drop_to_probe();
        repeat (29) begin
            pulse_tick();
            step();
        end
        pulse_tick();
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        step();
        step();
        tests++;
        if (newShape !== 1'b0 || game_over !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: newShape=%0b game_over=%0b want 0/0", newShape, game_over);
        end
        tests++;
        if (bif.probe_valid !== 1'b0 || bif.lock_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_handshake: probe_valid=%0b lock_valid=%0b want 0/0", bif.probe_valid, bif.lock_valid);
        end
        tests++;
        if (shape !== 7'd0 || sq_x[0] !== 10'd0 || sq_y[3] !== 10'd0) begin
            fails++;
            $display("FAIL reset_piece: shape=%0d sq_x0=%0d sq_y3=%0d want 0", shape, sq_x[0], sq_y[3]);
        end
        Reset = 1'b1;
    endtask

    task automatic test_spawn();
        int  pulses;
        logic seen;
        logic bad;
        pulses = 0;
        seen   = 1'b0;
        start  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (newShape) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL spawn_newshape: no newShape within 8 cycles, want pulse");
        end
        pulses = 1;
        start  = 1'b0;
        step();
        gen_x = bx;
        gen_y = by;
        gen_shape = 7'b0000001;
        if (newShape) pulses++;
        bad = 1'b0;
        for (int i = 0; i < 4; i++)
            if (sq_x[i] !== ax[i] || sq_y[i] !== ay[i]) bad = 1'b1;
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL spawn_coords: sq0=(%0d,%0d) sq3=(%0d,%0d) want (120,24) (144,72)", sq_x[0], sq_y[0], sq_x[3], sq_y[3]);
        end
        step();
        tests++;
        if (shape !== 7'b0000001) begin
            fails++;
            $display("FAIL spawn_shape: got %b want 0000001", shape);
        end
        bad = 1'b0;
        for (int i = 0; i < 4; i++)
            if (bif.probe_x[i] !== ax[i] || bif.probe_y[i] !== ay[i]) bad = 1'b1;
        tests++;
        if (bif.probe_valid !== 1'b1 || bad) begin
            fails++;
            $display("FAIL spawn_probe: probe_valid=%0b data_bad=%0b want 1/0", bif.probe_valid, bad);
        end
        gen_shape = 7'b0000010;
        bad = 1'b0;
        repeat (2) begin
            step();
            if (newShape) pulses++;
            if (bif.probe_valid !== 1'b1 || bif.probe_y[3] !== 10'd72) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL spawn_probe_hold: probe_valid=%0b probe_y3=%0d want 1/72", bif.probe_valid, bif.probe_y[3]);
        end
        ack_probe(1'b0);
        tests++;
        if (bif.probe_valid !== 1'b0 || pulses != 1) begin
            fails++;
            $display("FAIL spawn_release: probe_valid=%0b newShape_pulses=%0d want 0/1", bif.probe_valid, pulses);
        end
    endtask

    task automatic test_drop();
        logic early;
        logic [9:0] exp_y [4];
        logic bad;
        exp_y = '{10'd48, 10'd72, 10'd96, 10'd96};
        early = 1'b0;
        repeat (29) begin
            pulse_tick();
            step();
            if (bif.probe_valid) early = 1'b1;
        end
        tests++;
        if (early !== 1'b0) begin
            fails++;
            $display("FAIL drop_early: probe seen before tick 30, want none");
        end
        pulse_tick();
        bad = 1'b0;
        for (int i = 0; i < 4; i++)
            if (bif.probe_y[i] !== exp_y[i] || bif.probe_x[i] !== ax[i]) bad = 1'b1;
        tests++;
        if (bif.probe_valid !== 1'b1 || bad) begin
            fails++;
            $display("FAIL drop_probe: probe_valid=%0b probe_y0=%0d want 1/48", bif.probe_valid, bif.probe_y[0]);
        end
        ack_probe(1'b0);
        bad = 1'b0;
        for (int i = 0; i < 4; i++)
            if (sq_y[i] !== exp_y[i]) bad = 1'b1;
        tests++;
        if (bad || bif.probe_valid !== 1'b0) begin
            fails++;
            $display("FAIL drop_move: sq_y=%0d/%0d/%0d/%0d probe_valid=%0b want 48/72/96/96 0", sq_y[0], sq_y[1], sq_y[2], sq_y[3], bif.probe_valid);
        end
    endtask

    task automatic test_bottom();
        logic early;
        repeat (15) begin
            drop_to_probe();
            ack_probe(1'b0);
        end
        tests++;
        if (sq_y[0] !== 10'd408 || sq_y[1] !== 10'd432 || sq_y[2] !== 10'd456 || sq_y[3] !== 10'd456) begin
            fails++;
            $display("FAIL bottom_pos: sq_y=%0d/%0d/%0d/%0d want 408/432/456/456", sq_y[0], sq_y[1], sq_y[2], sq_y[3]);
        end
        early = 1'b0;
        repeat (29) begin
            pulse_tick();
            step();
            if (bif.probe_valid) early = 1'b1;
        end
        pulse_tick();
        if (bif.probe_valid) early = 1'b1;
        tests++;
        if (early !== 1'b0 || bif.lock_valid !== 1'b1 || sq_y[2] !== 10'd456) begin
            fails++;
            $display("FAIL bottom_lock: probe_seen=%0b lock_valid=%0b sq_y2=%0d want 0/1/456", early, bif.lock_valid, sq_y[2]);
        end
        bif.lock_ack = 1'b1;
        step();
        bif.lock_ack = 1'b0;
        tests++;
        if (newShape !== 1'b1 || bif.lock_valid !== 1'b0) begin
            fails++;
            $display("FAIL bottom_respawn: newShape=%0b lock_valid=%0b want 1/0", newShape, bif.lock_valid);
        end
    endtask

    task automatic test_drop_hit();
        logic held;
        step();
        step();
        ack_probe(1'b0);
        drop_to_probe();
        tests++;
        if (bif.probe_valid !== 1'b1 || bif.probe_y[0] !== 10'd24 || bif.probe_y[3] !== 10'd48) begin
            fails++;
            $display("FAIL hit_probe: probe_valid=%0b probe_y0=%0d probe_y3=%0d want 1/24/48", bif.probe_valid, bif.probe_y[0], bif.probe_y[3]);
        end
        ack_probe(1'b1);
        tests++;
        if (bif.lock_valid !== 1'b1 || sq_y[0] !== 10'd0 || sq_y[3] !== 10'd24 || sq_x[0] !== 10'd96 || shape !== 7'b0000010) begin
            fails++;
            $display("FAIL hit_lock: lock_valid=%0b sq_y0=%0d sq_y3=%0d shape=%b want 1/0/24/0000010", bif.lock_valid, sq_y[0], sq_y[3], shape);
        end
        held = 1'b1;
        repeat (5) begin
            step();
            if (bif.lock_valid !== 1'b1 || newShape !== 1'b0 || sq_y[3] !== 10'd24) held = 1'b0;
        end
        tests++;
        if (!held) begin
            fails++;
            $display("FAIL hit_hold: lock_valid=%0b newShape=%0b want 1/0 while waiting", bif.lock_valid, newShape);
        end
        bif.lock_ack = 1'b1;
        step();
        bif.lock_ack = 1'b0;
        tests++;
        if (newShape !== 1'b1 || bif.lock_valid !== 1'b0) begin
            fails++;
            $display("FAIL hit_respawn: newShape=%0b lock_valid=%0b want 1/0", newShape, bif.lock_valid);
        end
    endtask

    task automatic test_spawn_hit();
        logic stuck;
        step();
        step();
        tests++;
        if (bif.probe_valid !== 1'b1) begin
            fails++;
            $display("FAIL over_probe: probe_valid=%0b want 1", bif.probe_valid);
        end
        ack_probe(1'b1);
        tests++;
        if (game_over !== 1'b1 || bif.probe_valid !== 1'b0) begin
            fails++;
            $display("FAIL over_enter: game_over=%0b probe_valid=%0b want 1/0", game_over, bif.probe_valid);
        end
        stuck = 1'b1;
        repeat (4) begin
            step();
            if (game_over !== 1'b1 || newShape !== 1'b0) stuck = 1'b0;
        end
        tests++;
        if (!stuck) begin
            fails++;
            $display("FAIL over_hold: game_over=%0b newShape=%0b want 1/0", game_over, newShape);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        tests++;
        if (game_over !== 1'b0 || newShape !== 1'b1 || shape !== 7'd0 || sq_x[0] !== 10'd0 || sq_y[3] !== 10'd0) begin
            fails++;
            $display("FAIL over_restart: game_over=%0b newShape=%0b shape=%b sq_x0=%0d want 0/1/0/0", game_over, newShape, shape, sq_x[0]);
        end
    endtask

    task automatic test_fast_and_reset();
        step();
        step();
        ack_probe(1'b0);
        repeat (10) begin
            pulse_tick();
            step();
        end
        tests++;
        if (bif.probe_valid !== 1'b0) begin
            fails++;
            $display("FAIL fast_pre: probe_valid=%0b after 10 ticks want 0", bif.probe_valid);
        end
        fast_drop = 1'b1;
        pulse_tick();
        tests++;
        if (bif.probe_valid !== 1'b1 || bif.probe_y[0] !== 10'd24) begin
            fails++;
            $display("FAIL fast_step: probe_valid=%0b probe_y0=%0d want 1/24", bif.probe_valid, bif.probe_y[0]);
        end
        #2;
        Reset = 1'b0;
        #1;
        tests++;
        if (bif.probe_valid !== 1'b0 || bif.lock_valid !== 1'b0 || newShape !== 1'b0 || game_over !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_ctrl: probe_valid=%0b lock_valid=%0b newShape=%0b game_over=%0b want 0", bif.probe_valid, bif.lock_valid, newShape, game_over);
        end
        tests++;
        if (shape !== 7'd0 || sq_y[3] !== 10'd0 || sq_x[0] !== 10'd0 || bif.probe_y[0] !== 10'd0) begin
            fails++;
            $display("FAIL async_reset_data: shape=%b sq_y3=%0d sq_x0=%0d probe_y0=%0d want 0", shape, sq_y[3], sq_x[0], bif.probe_y[0]);
        end
        step();
        fast_drop = 1'b0;
        Reset = 1'b1;
    endtask

    initial begin
        bif.probe_ack = 1'b0;
        bif.probe_hit = 1'b0;
        bif.lock_ack  = 1'b0;
        gen_x = ax;
        gen_y = ay;
        gen_shape = 7'b1000000;
        test_reset();
        test_spawn();
        test_drop();
        test_bottom();
        test_drop_hit();
        test_spawn_hit();
        test_fast_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
